// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for a 5-stage MIPS-style core.
//
// Resolves the pipeline control for each cycle from a small amount of state
// (multiply/divide unit busy tracker plus a one-cycle exception hold) and the
// current hazard inputs.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   reset          synchronous, active-low reset
//   id_rs_addr     rs field of the instruction in ID
//   id_rt_addr     rt field of the instruction in ID
//   id_rs_used     ID instruction reads rs
//   id_rt_used     ID instruction reads rt
//   idex_mem_r     instruction in EX is a load
//   idex_rd_addr   destination register of the instruction in EX
//   id_md_use      ID instruction touches HI/LO (mult/div, mfhi/mflo, mthi/mtlo)
//   ex_md_start    mult/div enters EX this cycle (1-cycle pulse)
//   ex_md_div      qualifies ex_md_start: 1 = divide, 0 = multiply
//   ex_redirect    taken branch / jump resolved in EX
//   ex_exc         syscall or eret in EX
//   mem_wait       data memory not ready; freeze the whole pipeline
//   pc_stall       hold the PC
//   ifid_stall     hold the IF/ID register
//   ifid_flush     clear the IF/ID register
//   cu_stall       hold the ID/EX register
//   cu_flush       clear the ID/EX register (ignored when cu_stall = 1)
//   md_busy        multiply/divide unit is busy
//   md_count       remaining busy cycles of the multiply/divide unit
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       idex_mem_r,
    input  logic [4:0] idex_rd_addr,
    input  logic       id_md_use,
    input  logic       ex_md_start,
    input  logic       ex_md_div,
    input  logic       ex_redirect,
    input  logic       ex_exc,
    input  logic       mem_wait,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       cu_stall,
    output logic       cu_flush,
    output logic       md_busy,
    output logic [5:0] md_count
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [5:0] DIV_CYCLES  = 6'd32;
    localparam logic [5:0] MULT_CYCLES = 6'd4;

    md_state_t  md_state, md_state_nxt;
    logic [5:0] md_cnt, md_cnt_nxt;
    logic       exc_hold, exc_hold_nxt;

    logic       load_use;
    logic       md_hazard;
    logic       exception;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            md_state <= IDLE;
            md_cnt   <= 6'd0;
            exc_hold <= 1'b0;
        end else begin
            md_state <= md_state_nxt;
            md_cnt   <= md_cnt_nxt;
            exc_hold <= exc_hold_nxt;
        end
    end

    // Next-state logic. The MD counter keeps running through mem_wait
    // because the multiply/divide unit is not frozen by memory stalls;
    // only a new start is held off, since the issuing instruction is frozen.
    always_comb begin
        md_state_nxt = md_state;
        md_cnt_nxt   = md_cnt;
        // Extends a single-cycle exception into a two-cycle flush; a frozen
        // exception is not yet taken, so it does not arm the hold.
        exc_hold_nxt = ex_exc && !mem_wait;
        case (md_state)
            IDLE: begin
                if (ex_md_start && !mem_wait) begin
                    md_state_nxt = BUSY;
                    md_cnt_nxt   = ex_md_div ? DIV_CYCLES : MULT_CYCLES;
                end
            end
            BUSY: begin
                // A start seen here is ignored: no reload while busy.
                if (md_cnt == 6'd1) begin
                    md_state_nxt = IDLE;
                    md_cnt_nxt   = 6'd0;
                end else begin
                    md_cnt_nxt = md_cnt - 6'd1;
                end
            end
            default: begin
                md_state_nxt = IDLE;
                md_cnt_nxt   = 6'd0;
            end
        endcase
    end

    assign load_use  = idex_mem_r && (idex_rd_addr != 5'd0) &&
                       ((id_rs_used && (id_rs_addr == idex_rd_addr)) ||
                        (id_rt_used && (id_rt_addr == idex_rd_addr)));
    assign md_hazard = (md_state == BUSY) && id_md_use;
    assign exception = ex_exc || exc_hold;

    assign md_busy   = reset && (md_state == BUSY);
    assign md_count  = reset ? md_cnt : 6'd0;

    // Control outputs, highest priority first. Reset forces a flush so the
    // pipeline registers come out of reset holding bubbles.
    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        cu_stall   = 1'b0;
        cu_flush   = 1'b0;
        if (!reset) begin
            ifid_flush = 1'b1;
            cu_flush   = 1'b1;
        end else if (mem_wait) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            cu_stall   = 1'b1;
        end else if (exception || ex_redirect) begin
            ifid_flush = 1'b1;
            cu_flush   = 1'b1;
        end else if (md_hazard || load_use) begin
            // Hold the front end and insert a bubble into EX.
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            cu_flush   = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs_addr, id_rt_addr, idex_rd_addr;
    logic       id_rs_used, id_rt_used, idex_mem_r, id_md_use;
    logic       ex_md_start, ex_md_div, ex_redirect, ex_exc, mem_wait;
    logic       pc_stall, ifid_stall, ifid_flush, cu_stall, cu_flush, md_busy;
    logic [5:0] md_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: cycles of MD work left, and whether the
    // previous cycle took an exception.
    int m_left = 0;
    bit m_exc  = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs_addr  (id_rs_addr),
        .id_rt_addr  (id_rt_addr),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .idex_mem_r  (idex_mem_r),
        .idex_rd_addr(idex_rd_addr),
        .id_md_use   (id_md_use),
        .ex_md_start (ex_md_start),
        .ex_md_div   (ex_md_div),
        .ex_redirect (ex_redirect),
        .ex_exc      (ex_exc),
        .mem_wait    (mem_wait),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .cu_stall    (cu_stall),
        .cu_flush    (cu_flush),
        .md_busy     (md_busy),
        .md_count    (md_count)
    );

    // {pc_stall, ifid_stall, ifid_flush, cu_stall, cu_flush}
    localparam logic [4:0] C_NONE   = 5'b00000;
    localparam logic [4:0] C_FREEZE = 5'b11010;
    localparam logic [4:0] C_FLUSH  = 5'b00101;
    localparam logic [4:0] C_BUBBLE = 5'b11001;

    wire [4:0]  ctrl = {pc_stall, ifid_stall, ifid_flush, cu_stall, cu_flush};
    wire [11:0] obs  = {ctrl, md_busy, md_count};

    function automatic logic [4:0] exp_ctrl();
        bit lu, mdh;
        lu  = idex_mem_r && idex_rd_addr != 0 &&
              ((id_rs_used && id_rs_addr == idex_rd_addr) ||
               (id_rt_used && id_rt_addr == idex_rd_addr));
        mdh = (m_left > 0) && id_md_use;
        if (!reset)                return C_FLUSH;
        if (mem_wait)              return C_FREEZE;
        if (ex_exc || m_exc)       return C_FLUSH;
        if (ex_redirect)           return C_FLUSH;
        if (mdh || lu)             return C_BUBBLE;
        return C_NONE;
    endfunction

    function automatic logic [11:0] exp_vec();
        logic [5:0] cnt;
        cnt = reset ? 6'(m_left) : 6'd0;
        return {exp_ctrl(), (reset && m_left > 0), cnt};
    endfunction

    task automatic clear_inputs();
        id_rs_addr = 0; id_rt_addr = 0; idex_rd_addr = 0;
        id_rs_used = 0; id_rt_used = 0; idex_mem_r = 0; id_md_use = 0;
        ex_md_start = 0; ex_md_div = 0; ex_redirect = 0; ex_exc = 0; mem_wait = 0;
    endtask

    // Advance one clock: update the model with the inputs seen at the edge,
    // then return at the falling edge ready for new stimulus.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            m_left = 0;
            m_exc  = 1'b0;
        end else begin
            m_exc = ex_exc && !mem_wait;
            if (m_left > 0)
                m_left = m_left - 1;
            else if (ex_md_start && !mem_wait)
                m_left = ex_md_div ? 32 : 4;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex_exc = 1'b1; mem_wait = (i == 1); ex_md_start = 1'b1; ex_redirect = 1'b1;
            #1;
            tests_run++;
            if (obs !== {C_FLUSH, 1'b0, 6'd0}) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, {C_FLUSH, 1'b0, 6'd0});
            end
            tick();
        end
        clear_inputs();
        reset = 1'b1;
        #1;
        tests_run++;
        if (obs !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_release: got %b want %b", obs, 12'd0);
        end
        tick();
    endtask

    task automatic test_load_use();
        idex_mem_r = 1; idex_rd_addr = 8; id_rs_used = 1; id_rs_addr = 8;
        #1;
        tests_run++;
        if (ctrl !== C_BUBBLE) begin
            tests_failed++;
            $display("FAIL load_use_rs: got %b want %b", ctrl, C_BUBBLE);
        end
        idex_rd_addr = 0; id_rs_addr = 0;
        #1;
        tests_run++;
        if (ctrl !== C_NONE) begin
            tests_failed++;
            $display("FAIL load_use_r0: got %b want %b", ctrl, C_NONE);
        end
        id_rs_used = 0; id_rt_used = 1; id_rt_addr = 17; idex_rd_addr = 17;
        #1;
        tests_run++;
        if (ctrl !== C_BUBBLE) begin
            tests_failed++;
            $display("FAIL load_use_rt: got %b want %b", ctrl, C_BUBBLE);
        end
        idex_mem_r = 0;
        #1;
        tests_run++;
        if (ctrl !== C_NONE) begin
            tests_failed++;
            $display("FAIL load_use_noload: got %b want %b", ctrl, C_NONE);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_div();
        logic [11:0] want;
        ex_md_start = 1; ex_md_div = 1;
        tick();
        clear_inputs();
        for (int k = 1; k <= 34; k++) begin
            ex_md_start = (k == 5);
            ex_md_div   = 1'b0;
            id_md_use   = (k == 10) || (k == 33);
            #1;
            if (k <= 32)
                want = {(k == 10) ? C_BUBBLE : C_NONE, 1'b1, 6'(33 - k)};
            else
                want = {C_NONE, 1'b0, 6'd0};
            tests_run++;
            if (obs !== want) begin
                tests_failed++;
                $display("FAIL div_cycle[%0d]: got %b want %b", k, obs, want);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_exception();
        ex_exc = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (ctrl !== ((k < 2) ? C_FLUSH : C_NONE)) begin
                tests_failed++;
                $display("FAIL exc_pulse[%0d]: got %b want %b", k, ctrl, (k < 2) ? C_FLUSH : C_NONE);
            end
            tick();
            ex_exc = 0;
        end
        ex_exc = 1; mem_wait = 1;
        #1;
        tests_run++;
        if (ctrl !== C_FREEZE) begin
            tests_failed++;
            $display("FAIL exc_frozen: got %b want %b", ctrl, C_FREEZE);
        end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (ctrl !== C_NONE) begin
            tests_failed++;
            $display("FAIL exc_no_hold: got %b want %b", ctrl, C_NONE);
        end
        tick();
    endtask

    task automatic test_priority();
        ex_redirect = 1; idex_mem_r = 1; idex_rd_addr = 5; id_rs_used = 1; id_rs_addr = 5;
        #1;
        tests_run++;
        if (ctrl !== C_FLUSH) begin
            tests_failed++;
            $display("FAIL prio_redirect: got %b want %b", ctrl, C_FLUSH);
        end
        mem_wait = 1;
        #1;
        tests_run++;
        if (ctrl !== C_FREEZE) begin
            tests_failed++;
            $display("FAIL prio_memwait: got %b want %b", ctrl, C_FREEZE);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_mult();
        ex_md_start = 1; ex_md_div = 0;
        tick();
        clear_inputs();
        tick();
        tick();
        #1;
        tests_run++;
        if (obs !== {C_NONE, 1'b1, 6'd2}) begin
            tests_failed++;
            $display("FAIL mult_count2: got %b want %b", obs, {C_NONE, 1'b1, 6'd2});
        end
        reset = 0;
        tick();
        #1;
        tests_run++;
        if (obs !== {C_FLUSH, 1'b0, 6'd0}) begin
            tests_failed++;
            $display("FAIL mult_reset: got %b want %b", obs, {C_FLUSH, 1'b0, 6'd0});
        end
        reset = 1;
        #1;
        tests_run++;
        if (obs !== 12'd0) begin
            tests_failed++;
            $display("FAIL mult_after_reset: got %b want %b", obs, 12'd0);
        end
        // Exception hold armed, then reset: no flush after release.
        ex_exc = 1;
        tick();
        ex_exc = 0; reset = 0;
        tick();
        reset = 1;
        #1;
        tests_run++;
        if (obs !== 12'd0) begin
            tests_failed++;
            $display("FAIL exc_hold_reset: got %b want %b", obs, 12'd0);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 39) != 0);
            mem_wait     = ($urandom_range(0, 5) == 0);
            ex_exc       = ($urandom_range(0, 11) == 0);
            ex_redirect  = ($urandom_range(0, 7) == 0);
            ex_md_start  = ($urandom_range(0, 5) == 0);
            ex_md_div    = ($urandom_range(0, 3) == 0);
            id_md_use    = ($urandom_range(0, 2) == 0);
            idex_mem_r   = $urandom_range(0, 1);
            id_rs_used   = $urandom_range(0, 1);
            id_rt_used   = $urandom_range(0, 1);
            idex_rd_addr = 5'($urandom_range(0, 3));
            id_rs_addr   = 5'($urandom_range(0, 3));
            id_rt_addr   = 5'($urandom_range(0, 3));
            #1;
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %b want %b", i, obs, exp_vec());
            end
            tick();
        end
        clear_inputs();
        reset = 1;
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_div();
        test_exception();
        test_priority();
        test_reset_mid_mult();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 reset  in  1  active-low, synchronous: sampled only at posedge clk; low = reset.
REQ-003 id_rs_addr  in  5  rs field of the instruction in ID.
REQ-004 id_rt_addr  in  5  rt field of the instruction in ID.
REQ-005 id_rs_used / id_rt_used  in  1 each  ID instruction reads rs / rt.
REQ-006 idex_mem_r  in  1  instruction in EX is a load.
REQ-007 idex_rd_addr  in  5  destination register of the instruction in EX.
REQ-008 id_md_use  in  1  ID instruction is a mult/div, mfhi/mflo or mthi/mtlo (touches HI/LO).
REQ-009 ex_md_start  in  1  mult/div enters EX this cycle (1-cycle pulse).
REQ-010 ex_md_div  in  1  qualifies ex_md_start: 1 = div/divu, 0 = mult/multu.
REQ-011 ex_redirect  in  1  taken branch, jmp or jr resolved in EX.
REQ-012 ex_exc  in  1  syscall or eret in EX.
REQ-013 mem_wait  in  1  data memory not ready; whole pipeline must freeze.
REQ-014 pc_stall  out  1  hold PC.
REQ-015 ifid_stall / ifid_flush  out  1 each  hold / clear the IF/ID register.
REQ-016 cu_stall / cu_flush  out  1 each  hold / clear the ID/EX register (flush honoured only when cu_stall = 0).
REQ-017 md_busy  out  1  multiply/divide unit is busy.
REQ-018 md_count  out  6  remaining busy cycles.

Function
REQ-019 Registered state SHALL be exactly: md_state {IDLE, BUSY}, md_count[5:0], exc_hold (1 bit); all outputs SHALL be combinational from this state and the current inputs.
REQ-020 Load-use hazard SHALL be: idex_mem_r && idex_rd_addr != 0 && ((id_rs_used && id_rs_addr == idex_rd_addr) || (id_rt_used && id_rt_addr == idex_rd_addr)).
REQ-021 MD hazard SHALL be: md_state == BUSY && id_md_use.
REQ-022 Output priority SHALL be, highest first: mem_wait > exception > redirect > MD hazard > load-use > none.
REQ-023 mem_wait: pc_stall = ifid_stall = cu_stall = 1; both flushes = 0.
REQ-024 Exception (ex_exc || exc_hold): ifid_flush = cu_flush = 1; all stalls = 0.
REQ-025 Redirect: ifid_flush = cu_flush = 1; all stalls = 0.
REQ-026 MD hazard or load-use: pc_stall = ifid_stall = 1; cu_flush = 1 (bubble); cu_stall = 0; ifid_flush = 0.
REQ-027 None: all five control outputs = 0.
REQ-028 exc_hold SHALL be set to 1 at a posedge where ex_exc = 1 and mem_wait = 0; otherwise cleared, so an exception flushes exactly 2 consecutive cycles.
REQ-029 In IDLE, ex_md_start = 1 with mem_wait = 0 SHALL load md_count = 32 if ex_md_div, else 4, and enter BUSY.
REQ-030 In BUSY, md_count SHALL decrement by 1 every cycle, including while mem_wait = 1; at md_count == 1 the next state SHALL be IDLE with md_count = 0.
REQ-031 ex_md_start while BUSY SHALL be ignored: no reload, no state change.
REQ-032 md_busy SHALL equal (md_state == BUSY); md_count SHALL be 0 in IDLE.
REQ-033 ex_exc and ex_redirect SHALL NOT abort a running MD operation.

Reset
REQ-034 reset = 0 at posedge clk: md_state = IDLE, md_count = 0, exc_hold = 0.
REQ-035 While reset = 0: all stalls = 0, ifid_flush = cu_flush = 1, md_busy = 0, md_count = 0, regardless of other inputs.
REQ-036 Reset asserted mid-BUSY or with exc_hold = 1 SHALL abandon the operation; the first cycle after release SHALL be IDLE with no flush.

Verification
REQ-037 Load-use: idex_mem_r = 1, idex_rd_addr = 8, id_rs_used = 1, id_rs_addr = 8 -> pc_stall = ifid_stall = cu_flush = 1, cu_stall = 0; same with idex_rd_addr = 0 -> all control outputs 0.
REQ-038 Div: ex_md_start = 1, ex_md_div = 1 -> md_busy = 1 and md_count = 32 next cycle, decrementing to IDLE after 32 cycles; id_md_use = 1 in cycle 10 -> bubble; ex_md_start at cycle 5 ignored.
REQ-039 Exception: single-cycle ex_exc pulse -> ifid_flush = cu_flush = 1 for exactly 2 cycles; ex_exc with mem_wait = 1 -> freeze only, exc_hold stays 0.
REQ-040 Priority: ex_redirect = 1 with a simultaneous load-use hazard -> flushes only, stalls = 0; mem_wait = 1 on top -> stalls only, flushes = 0.
REQ-041 Reset mid-mult at md_count = 2 -> md_busy = 0, md_count = 0 immediately after the reset posedge; flushes = 1 while reset = 0.
